// File: rtl/cpu_pkg.sv
// Shared miniRV definitions: next-PC select encodings, the canonical nop,
// and the fetch-stage state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    NPC_BR   = 2'b00,
    NPC_JALR = 2'b01,
    NPC_PC4  = 2'b10,
    NPC_JAL  = 2'b11
  } npc_op_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_FETCH = 2'd1,
    IF_VALID = 2'd2,
    IF_HALT  = 2'd3
  } if_state_e;

endpackage

// File: rtl/ifetch_if.sv
// Instruction-memory handshake plus the decode-side instruction/retire bundle.
interface ifetch_if;
  import cpu_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        inst_ready;
  npc_op_e     npc_op;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        halted;

  modport master (
    output imem_req, imem_addr, inst, inst_pc, pc_plus4, inst_valid, halted,
    input  imem_ack, imem_rdata, inst_ready, npc_op, branch_taken, imm, rs1_data
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, pc_plus4, inst_valid, halted,
    output imem_ack, imem_rdata, inst_ready, npc_op, branch_taken, imm, rs1_data
  );

endinterface

// File: rtl/npc_calc.sv
// Combinational next-PC selection with misalignment detection.
module npc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  npc_op_e     npc_op,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] pc_imm;
  logic [31:0] pc_4;
  logic [31:0] rs1_imm;

  assign pc_imm  = pc + imm;
  assign pc_4    = pc + 32'd4;
  assign rs1_imm = rs1_data + imm;

  always_comb begin
    npc = pc_4;
    unique case (npc_op)
      NPC_BR:   npc = branch_taken ? pc_imm : pc_4;
      NPC_JALR: npc = {rs1_imm[31:1], 1'b0};
      NPC_PC4:  npc = pc_4;
      NPC_JAL:  npc = pc_imm;
      default:  npc = pc_4;
    endcase
  end

  // bit0 is already cleared for jalr, so one test covers every op
  assign misalign = |npc[1:0];

endmodule

// File: rtl/ifetch.sv
// Fetch stage: owns the PC, runs the imem req/ack handshake and hands one
// instruction at a time to decode, advancing the PC when it retires.
//
// state | meaning
// IDLE  | one cycle after reset release, no request
// FETCH | imem_req high at PC, waiting for imem_ack
// VALID | inst presented to decode, waiting for inst_ready
// HALT  | misaligned target seen, frozen until reset
module ifetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic      clk,
  input logic      rst,
  ifetch_if.master bus
);

  if_state_e   state;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic [31:0] npc;
  logic        misalign;

  npc_calc u_npc_calc (
    .pc           (pc),
    .npc_op       (bus.npc_op),
    .branch_taken (bus.branch_taken),
    .imm          (bus.imm),
    .rs1_data     (bus.rs1_data),
    .npc          (npc),
    .misalign     (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IF_IDLE;
      pc        <= RESET_PC;
      inst_q    <= NOP_INST;
      inst_pc_q <= RESET_PC;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      unique case (state)
        IF_IDLE: begin
          req_q <= 1'b1;
          state <= IF_FETCH;
        end
        IF_FETCH: begin
          if (bus.imem_ack) begin
            inst_q    <= bus.imem_rdata;
            inst_pc_q <= pc;
            req_q     <= 1'b0;
            valid_q   <= 1'b1;
            state     <= IF_VALID;
          end
        end
        IF_VALID: begin
          if (bus.inst_ready) begin
            valid_q <= 1'b0;
            if (misalign) begin
              halted_q <= 1'b1;
              state    <= IF_HALT;
            end else begin
              pc    <= npc;
              req_q <= 1'b1;
              state <= IF_FETCH;
            end
          end
        end
        IF_HALT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state <= IF_IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc_plus4   = inst_pc_q + 32'd4;
  assign bus.inst_valid = valid_q;
  assign bus.halted     = halted_q;

endmodule
